// File: rtl/fir_pkg.sv
// Shared state encoding and default geometry for the FIR MAC sequencer.
package fir_pkg;

  localparam int FIR_TAPS     = 8;
  localparam int FIR_DATA_W   = 16;
  localparam int FIR_ACC_W    = 25;
  localparam int FIR_OUT_W    = 20;
  localparam int FIR_PIPE_LAT = 2;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    OUT
  } fir_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fir_tap_addr_gen.sv
// Modulo-TAPS pointer arithmetic for the circular delay line.
module fir_tap_addr_gen #(
  parameter int TAPS   = 8,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic [ADDR_W-1:0] wptr,
  input  logic [ADDR_W-1:0] k,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] wptr_inc
);

  // Read address (wptr-k) mod TAPS and wrapping write-pointer increment.
  // wptr+TAPS-k is always below TAPS <= 2**ADDR_W, so ADDR_W-bit modular
  // arithmetic yields the exact value even when TAPS truncates to zero.
  always_comb begin
    if (wptr >= k) begin
      raddr = wptr - k;
    end else begin
      raddr = wptr + ADDR_W'(TAPS) - k;
    end
    wptr_inc = (wptr == ADDR_W'(TAPS - 1)) ? '0 : wptr + ADDR_W'(1);
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a time-multiplexed single-MAC FIR: delay-line write, tap
// stepping, pipeline drain and output capture.
import fir_pkg::*;

module fir_mac_sequencer #(
  parameter int TAPS     = FIR_TAPS,
  parameter int DATA_W   = FIR_DATA_W,
  parameter int ACC_W    = FIR_ACC_W,
  parameter int OUT_W    = FIR_OUT_W,
  parameter int PIPE_LAT = FIR_PIPE_LAT,
  parameter int ADDR_W   = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  output logic              dl_we,
  output logic [ADDR_W-1:0] dl_waddr,
  output logic [DATA_W-1:0] dl_wdata,
  output logic [ADDR_W-1:0] dl_raddr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  acc,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              overrun
);

  // Shared tap / init / drain counter; PIPE_LAT is assumed >= 1.
  localparam int CNT_W = $clog2(max_int(TAPS, PIPE_LAT));

  fir_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] wptr, wptr_n, wptr_inc, raddr;
  logic [DATA_W-1:0] sample_q;
  logic              go;
  logic              acc_unused;

  assign acc_unused = ^acc[ACC_W-OUT_W-1:0];

  fir_tap_addr_gen #(
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .wptr     (wptr),
    .k        (cnt[ADDR_W-1:0]),
    .raddr    (raddr),
    .wptr_inc (wptr_inc)
  );

  // State, counter and write pointer. go holds INIT for the first cycle after
  // reset release so every strobe stays low while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
      wptr  <= '0;
      go    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      wptr  <= wptr_n;
      go    <= 1'b1;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wptr_n  = wptr;
    if (flush) begin
      state_n = INIT;
      cnt_n   = '0;
      wptr_n  = '0;
    end else begin
      case (state)
        INIT: begin
          if (go) begin
            if (cnt == CNT_W'(TAPS - 1)) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        IDLE: begin
          if (in_valid) state_n = LOAD;
        end
        LOAD: begin
          state_n = MAC;
          cnt_n   = '0;
        end
        MAC: begin
          if (cnt == CNT_W'(TAPS - 1)) begin
            state_n = DRAIN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (cnt == CNT_W'(PIPE_LAT - 1)) begin
            state_n = OUT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        OUT: begin
          state_n = IDLE;
          wptr_n  = wptr_inc;
        end
        default: begin
          state_n = INIT;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Datapath controls decoded from the registered state.
  always_comb begin
    in_ready  = (state == IDLE) && !flush;
    dl_we     = 1'b0;
    dl_waddr  = '0;
    dl_wdata  = '0;
    dl_raddr  = '0;
    coef_addr = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      INIT: begin
        dl_we    = go;
        dl_waddr = cnt[ADDR_W-1:0];
      end
      LOAD: begin
        dl_we    = 1'b1;
        dl_waddr = wptr;
        dl_wdata = sample_q;
        mac_clr  = 1'b1;
      end
      MAC: begin
        mac_en    = 1'b1;
        coef_addr = cnt[ADDR_W-1:0];
        dl_raddr  = raddr;
      end
      default: ;
    endcase
  end

  // Sample latch, output capture and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid && in_ready) sample_q <= in_sample;
      out_valid <= (state == OUT) && !flush;
      if ((state == OUT) && !flush) out_data <= acc[ACC_W-1 -: OUT_W];
      if (flush) begin
        overrun <= 1'b0;
      end else if (in_valid && !in_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: coefficient ROM, delay-line RAM and pipelined
// MAC environment, a cycle-level reference model and directed scenarios.
module tb_fir_mac_sequencer;

  localparam int TAPS     = 8;
  localparam int DATA_W   = 16;
  localparam int ACC_W    = 25;
  localparam int OUT_W    = 20;
  localparam int PIPE_LAT = 2;
  localparam int ADDR_W   = 3;
  localparam int PERIOD_N = TAPS + PIPE_LAT + 3;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample;
  logic              dl_we;
  logic [ADDR_W-1:0] dl_waddr;
  logic [DATA_W-1:0] dl_wdata;
  logic [ADDR_W-1:0] dl_raddr;
  logic [ADDR_W-1:0] coef_addr;
  logic              mac_clr;
  logic              mac_en;
  logic [ACC_W-1:0]  acc;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fir_mac_sequencer #(
    .TAPS     (TAPS),
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .PIPE_LAT (PIPE_LAT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sample (in_sample),
    .dl_we     (dl_we),
    .dl_waddr  (dl_waddr),
    .dl_wdata  (dl_wdata),
    .dl_raddr  (dl_raddr),
    .coef_addr (coef_addr),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .acc       (acc),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Environment: coefficient ROM, delay-line RAM, one product stage + accumulator.
  int                coef [TAPS] = '{16, 32, -8, 64, 100, 3, -1, 255};
  logic [DATA_W-1:0] mem  [TAPS];
  logic              stage_v;
  logic [ACC_W-1:0]  stage_p;
  logic [ACC_W-1:0]  acc_r;
  assign acc = acc_r;

  always @(posedge clk) begin
    if (dl_we) mem[dl_waddr] <= dl_wdata;
    stage_v <= mac_en;
    stage_p <= ACC_W'(int'($signed(mem[dl_raddr])) * coef[coef_addr]);
    if (mac_clr) acc_r <= '0;
    else if (stage_v) acc_r <= acc_r + stage_p;
  end

  // Reference model state.
  int               hist[$];
  logic [OUT_W-1:0] got[$];
  int               n_out      = 0;
  bit               in_rst     = 1'b0;
  bit               pend       = 1'b0;
  int               pend_t     = 0;
  logic [OUT_W-1:0] pend_val   = '0;
  logic [OUT_W-1:0] held       = '0;
  bit               ov         = 1'b0;
  int               cur_t      = -1000;
  int               init_start = -1000;
  int               busy_until = 1 << 30;
  int               wptr_m     = 0;
  logic [DATA_W-1:0] last_smp  = '0;

  function automatic logic [OUT_W-1:0] model_out();
    longint      s;
    logic [63:0] sv;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      if (hist.size() - 1 - k >= 0) s = s + longint'(coef[k]) * hist[hist.size() - 1 - k];
    end
    sv = s;
    return sv[ACC_W-1 -: OUT_W];
  endfunction

  // Compare process: every cycle, outputs versus model expectations.
  always @(negedge clk) begin
    bit ready_e, in_init, in_load, in_mac, valid_e;
    int k;
    if (!reset) begin
      in_rst = 1'b1;
      chk("rst_dl_we", dl_we, 0);
      chk("rst_mac_en", mac_en, 0);
      chk("rst_mac_clr", mac_clr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_in_ready", in_ready, 0);
      hist.delete();
      pend = 1'b0; held = '0; ov = 1'b0;
      cur_t = -1000; init_start = -1000; busy_until = 1 << 30;
    end else begin
      if (in_rst) begin
        in_rst = 1'b0;
        init_start = cyc;
        busy_until = cyc + TAPS + 1;
      end
      ready_e = !flush && (cyc >= busy_until);
      in_init = (cyc > init_start) && (cyc <= init_start + TAPS);
      in_load = (cyc == cur_t + 1);
      k       = cyc - cur_t - 2;
      in_mac  = (k >= 0) && (k < TAPS);
      valid_e = pend && (cyc == pend_t + PERIOD_N);
      if (valid_e) begin
        held = pend_val;
        pend = 1'b0;
      end
      chk("in_ready", in_ready, ready_e);
      chk("dl_we", dl_we, in_init || in_load);
      chk("mac_clr", mac_clr, in_load);
      chk("mac_en", mac_en, in_mac);
      chk("out_valid", out_valid, valid_e);
      chk("out_data", out_data, held);
      chk("overrun", overrun, ov);
      if (in_init) begin
        chk("init_waddr", dl_waddr, cyc - init_start - 1);
        chk("init_wdata", dl_wdata, 0);
      end
      if (in_load) begin
        chk("load_waddr", dl_waddr, wptr_m);
        chk("load_wdata", dl_wdata, last_smp);
      end
      if (in_mac) begin
        chk("coef_addr", coef_addr, k);
        chk("dl_raddr", dl_raddr, (wptr_m - k + TAPS) % TAPS);
      end
      if (out_valid) begin
        got.push_back(out_data);
        n_out = n_out + 1;
      end
      if (flush) begin
        hist.delete();
        pend = 1'b0; cur_t = -1000; ov = 1'b0;
        init_start = cyc;
        busy_until = cyc + TAPS + 1;
      end else begin
        if (in_valid && !ready_e) ov = 1'b1;
        if (in_valid && ready_e) begin
          wptr_m = hist.size() % TAPS;
          hist.push_back(int'($signed(in_sample)));
          last_smp = in_sample;
          pend = 1'b1; pend_t = cyc; pend_val = model_out();
          cur_t = cyc;
          busy_until = cyc + PERIOD_N;
        end
      end
    end
  end

  // Offer one sample once in_ready is seen; returns #1 into the cycle after the handshake.
  task automatic send(input logic [DATA_W-1:0] x);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_wait_bound", n < 100, 1);
    in_valid  = 1'b1;
    in_sample = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  int exp_rd [TAPS] = '{0, 7, 6, 5, 4, 3, 2, 1};

  initial begin
    int               n_acc;
    int               snap;
    logic [OUT_W-1:0] prev;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sample = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dl_we", dl_we, 0);
    chk("reset_out_data", out_data, 0);
    reset = 1'b1;

    // INIT: eight zero writes, then ready.
    for (int i = 0; i < TAPS; i++) begin
      @(posedge clk); #1;
      chk("init_we", dl_we, 1);
      chk("init_addr", dl_waddr, i);
      chk("init_ready_low", in_ready, 0);
    end
    @(posedge clk); #1;
    chk("init_ready_high", in_ready, 1);
    chk("init_overrun", overrun, 0);

    // Impulse response.
    send(16'h7FFF);
    repeat (7) send(16'h0000);
    repeat (PERIOD_N + 1) @(posedge clk);
    #1;
    chk("impulse_count", n_out, 8);
    if (got.size() >= 3) begin
      chk("impulse_y0", got[0], 20'h03FFF);
      chk("impulse_y1", got[1], 20'h07FFF);
      chk("impulse_y2", got[2], 20'hFE000);
    end else begin
      chk("impulse_got_size", got.size(), 3);
    end

    // Ninth sample since INIT: write pointer wrapped to 0.
    send(16'h1234);
    for (int i = 0; i < TAPS; i++) begin
      @(posedge clk); #1;
      chk("wrap_raddr", dl_raddr, exp_rd[i]);
    end
    send(16'hF000);

    // Continuous offer: overrun on first refusal, one accept per period.
    n_acc = 0;
    in_valid = 1'b1;
    in_sample = 16'h0100;
    for (int i = 0; i < 3 * PERIOD_N; i++) begin
      if (i == 0) chk("overrun_before", overrun, 0);
      if (i == 1) chk("overrun_first", overrun, 1);
      if (in_ready) n_acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("overrun_accepts", n_acc, 3);

    // Flush at tap 4.
    send(16'h0200);
    repeat (5) @(posedge clk);
    #1;
    chk("flush_at_k4", coef_addr, 4);
    prev = out_data;
    snap = n_out;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_init_we", dl_we, 1);
    chk("flush_init_addr", dl_waddr, 0);
    chk("flush_overrun", overrun, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("flush_no_out", n_out, snap);
    chk("flush_out_hold", out_data, prev);

    // Asynchronous reset in the first drain cycle.
    send(16'h0300);
    repeat (9) @(posedge clk);
    #1;
    snap = n_out;
    #1 reset = 1'b0;
    #1;
    chk("arst_dl_we", dl_we, 0);
    chk("arst_mac_en", mac_en, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("arst_init_we", dl_we, 1);
    chk("arst_init_addr", dl_waddr, 0);
    send(16'h0400);
    send(16'h8000);
    repeat (PERIOD_N + 1) @(posedge clk);
    #1;
    chk("arst_outputs", n_out, snap + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
